xil_bram_sdp_arb: RTL and testbench

Arbiter and sequencer that shares one single-clock simple-dual-port block RAM (`xil_bram_sdp_1clk_wrap` style: `wen/wad/wda`, `ren/rad/rda`, read latency `DEL`) between two write clients and two read clients. After reset, or on request, it first sweeps the whole RAM to zero. It then grants the write port and the read port independently with round-robin fairness and returns read data tagged with the requesting client's id. It sits between packet-processing engines and the RAM wrapper.

---
 rtl/xil_bram_sdp_arb_if.sv | 31 +++
 rtl/xil_bram_sdp_arb.sv | 123 ++++++++++++
 tb/tb_xil_bram_sdp_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/xil_bram_sdp_arb_if.sv
// Client-side bus of the shared SDP block RAM arbiter: two write clients, two read
// clients and the tagged read-return channel.
interface xil_bram_sdp_arb_if #(
  parameter int unsigned ADR = 10,
  parameter int unsigned DAT = 18
) ();
  logic           w0_req, w1_req;
  logic [ADR-1:0] w0_ad, w1_ad;
  logic [DAT-1:0] w0_da, w1_da;
  logic           w0_ack, w1_ack;
  logic           r0_req, r1_req;
  logic [ADR-1:0] r0_ad, r1_ad;
  logic           r0_ack, r1_ack;
  logic           rd_vld;
  logic           rd_id;
  logic [DAT-1:0] rd_da;

  modport master (
    output w0_req, w1_req, w0_ad, w1_ad, w0_da, w1_da,
    output r0_req, r1_req, r0_ad, r1_ad,
    input  w0_ack, w1_ack, r0_ack, r1_ack,
    input  rd_vld, rd_id, rd_da
  );

  modport slave (
    input  w0_req, w1_req, w0_ad, w1_ad, w0_da, w1_da,
    input  r0_req, r1_req, r0_ad, r1_ad,
    output w0_ack, w1_ack, r0_ack, r1_ack,
    output rd_vld, rd_id, rd_da
  );
endinterface

// File: rtl/xil_bram_sdp_arb.sv
// Shares one single-clock simple-dual-port block RAM between two writers and two readers.
// Zero-sweeps the RAM after reset or on request, then round-robins each port independently.
module xil_bram_sdp_arb #(
  parameter int unsigned ADR = 10,
  parameter int unsigned DAT = 18,
  parameter int unsigned DEP = 1024,
  parameter int unsigned DEL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 busy,
  xil_bram_sdp_arb_if.slave    bus,
  output logic                 mem_wen,
  output logic [ADR-1:0]       mem_wad,
  output logic [DAT-1:0]       mem_wda,
  output logic                 mem_ren,
  output logic [ADR-1:0]       mem_rad,
  input  logic [DAT-1:0]       mem_rda
);

  localparam logic [ADR-1:0] LastCnt = ADR'(DEP - 1);

  typedef enum logic [0:0] {StClr, StRun} state_e;

  state_e         state_q, state_d;
  logic [ADR-1:0] cnt_q, cnt_d;
  logic           wptr_q, wptr_d;
  logic           rptr_q, rptr_d;
  logic [DEL-1:0] vld_q, vld_d;
  logic [DEL-1:0] id_q, id_d;

  logic run, clr;
  logic wwin, wgnt, rwin, rgnt;

  always_comb begin
    // rst is folded in so the reset cycle itself shows idle outputs
    run  = (state_q == StRun) && !rst;
    clr  = (state_q == StClr) && !rst;
    busy = rst || (state_q == StClr);

    wwin = (bus.w0_req && bus.w1_req) ? wptr_q : bus.w1_req;
    wgnt = run && (bus.w0_req || bus.w1_req);
    rwin = (bus.r0_req && bus.r1_req) ? rptr_q : bus.r1_req;
    rgnt = run && (bus.r0_req || bus.r1_req);

    bus.w0_ack = wgnt && !wwin;
    bus.w1_ack = wgnt && wwin;
    bus.r0_ack = rgnt && !rwin;
    bus.r1_ack = rgnt && rwin;

    mem_wen = 1'b0;
    mem_wad = '0;
    mem_wda = '0;
    if (clr) begin
      mem_wen = 1'b1;
      mem_wad = cnt_q;
    end else if (wgnt) begin
      mem_wen = 1'b1;
      mem_wad = wwin ? bus.w1_ad : bus.w0_ad;
      mem_wda = wwin ? bus.w1_da : bus.w0_da;
    end

    mem_ren = rgnt;
    mem_rad = rgnt ? (rwin ? bus.r1_ad : bus.r0_ad) : '0;

    wptr_d = wgnt ? !wwin : wptr_q;
    rptr_d = rgnt ? !rwin : rptr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClr: begin
        if (cnt_q == LastCnt) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (clr_req) begin
          state_d = StClr;
          cnt_d   = '0;
        end
      end
      default: state_d = StClr;
    endcase

    // Return tags keep flowing through a sweep; only rst flushes them
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = rgnt;
    id_d[0]  = rgnt && rwin;
    for (int i = 1; i < int'(DEL); i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end

    bus.rd_vld = vld_q[DEL-1] && !rst;
    bus.rd_id  = id_q[DEL-1] && !rst;
    bus.rd_da  = mem_rda;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClr;
      cnt_q   <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      vld_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_xil_bram_sdp_arb.sv
// Directed bench for xil_bram_sdp_arb with DEP=16, DEL=2 and a read-first RAM model.
module tb_xil_bram_sdp_arb;
  localparam int unsigned ADR = 10;
  localparam int unsigned DAT = 18;
  localparam int unsigned DEP = 16;
  localparam int unsigned DEL = 2;

  logic           clk, rst, clr_req, busy;
  logic           mem_wen, mem_ren;
  logic [ADR-1:0] mem_wad, mem_rad;
  logic [DAT-1:0] mem_wda, mem_rda;

  int n_checks, n_errors;

  xil_bram_sdp_arb_if #(.ADR(ADR), .DAT(DAT)) bus ();

  xil_bram_sdp_arb #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .DEL(DEL)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .bus     (bus),
    .mem_wen (mem_wen),
    .mem_wad (mem_wad),
    .mem_wda (mem_wda),
    .mem_ren (mem_ren),
    .mem_rad (mem_rad),
    .mem_rda (mem_rda)
  );

  // Read-first RAM with two cycles of read latency
  logic [DAT-1:0] model [1024];
  logic [DAT-1:0] rd_s1;
  always @(posedge clk) begin
    if (mem_wen) model[mem_wad] <= mem_wda;
    rd_s1   <= model[mem_rad];
    mem_rda <= rd_s1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [DAT-1:0] dat;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clr_req = 1'b0;
    bus.w0_req = 1'b0; bus.w1_req = 1'b0;
    bus.w0_ad = '0; bus.w1_ad = '0; bus.w0_da = '0; bus.w1_da = '0;
    bus.r0_req = 1'b1; bus.r1_req = 1'b0;
    bus.r0_ad = '0; bus.r1_ad = '0;

    repeat (2) begin
      @(negedge clk); #1;
      check("rst_state", {busy, mem_wen, mem_ren, bus.w0_ack, bus.w1_ack, bus.r0_ack,
                          bus.r1_ack, bus.rd_vld, bus.rd_id}, 9'b100000000);
    end

    // Sweep after reset release, r0 held throughout
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #1;
      check("sweep", {busy, mem_wen, mem_ren, bus.r0_ack, mem_wad, mem_wda},
            {4'b1100, 10'(c), 18'h0});
    end
    @(negedge clk); #1;
    check("first_rd_gnt", {busy, mem_wen, mem_ren, bus.r0_ack, bus.r1_ack, mem_rad},
          {5'b00110, 10'd0});
    @(negedge clk); bus.r0_req = 1'b0; #1;
    check("rd_lat1", bus.rd_vld, 1'b0);
    @(negedge clk); #1;
    check("first_rd_ret", {bus.rd_vld, bus.rd_id, bus.rd_da}, {2'b10, 18'h0});

    // Collision: write and read of address 7 in the same cycle
    @(negedge clk);
    bus.w1_req = 1'b1; bus.w1_ad = 10'd7; bus.w1_da = 18'h3;
    bus.r1_req = 1'b1; bus.r1_ad = 10'd7;
    #1;
    check("col_gnt", {bus.w0_ack, bus.w1_ack, bus.r0_ack, bus.r1_ack, mem_wen, mem_ren,
                      mem_wad, mem_rad, mem_wda}, {6'b010111, 10'd7, 10'd7, 18'h3});
    @(negedge clk); bus.w1_req = 1'b0; bus.r1_req = 1'b0; #1;
    @(negedge clk); #1;
    check("col_ret", {bus.rd_vld, bus.rd_id, bus.rd_da}, {2'b11, 18'h0});

    // Both writers held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.w0_req = 1'b1; bus.w0_ad = 10'd3; bus.w0_da = 18'h155;
        bus.w1_req = 1'b1; bus.w1_ad = 10'd5; bus.w1_da = 18'h0AA;
      end
      #1;
      if (i % 2 == 0)
        check("wr_arb", {bus.w0_ack, bus.w1_ack, mem_wen, mem_wad, mem_wda},
              {3'b101, 10'd3, 18'h155});
      else
        check("wr_arb", {bus.w0_ack, bus.w1_ack, mem_wen, mem_wad, mem_wda},
              {3'b011, 10'd5, 18'h0AA});
    end
    @(negedge clk); bus.w0_req = 1'b0; bus.w1_req = 1'b0; #1;
    check("wr_idle", {bus.w0_ack, bus.w1_ack, mem_wen}, 3'b000);
    check("ram3", model[3], 18'h155);
    check("ram5", model[5], 18'h0AA);

    // Both readers held for four grants
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.r0_req = 1'b1; bus.r0_ad = 10'd3;
        bus.r1_req = 1'b1; bus.r1_ad = 10'd5;
      end
      if (i == 4) begin
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      end
      #1;
      if (i < 4) begin
        if (i % 2 == 0)
          check("rd_arb", {bus.r0_ack, bus.r1_ack, mem_ren, mem_rad}, {3'b101, 10'd3});
        else
          check("rd_arb", {bus.r0_ack, bus.r1_ack, mem_ren, mem_rad}, {3'b011, 10'd5});
      end else begin
        check("rd_idle", {bus.r0_ack, bus.r1_ack, mem_ren}, 3'b000);
      end
      if (i < 2) begin
        check("rd_pre", bus.rd_vld, 1'b0);
      end else begin
        dat = (i % 2 == 0) ? 18'h155 : 18'h0AA;
        check("rd_seq", {bus.rd_vld, bus.rd_id, bus.rd_da}, {1'b1, 1'(i % 2), dat});
      end
    end

    // clr_req with a read issued in the pulse cycle
    @(negedge clk);
    clr_req = 1'b1; bus.r0_req = 1'b1; bus.r0_ad = 10'd3;
    #1;
    check("clr_pulse_gnt", {busy, bus.r0_ack, mem_ren, mem_rad}, {3'b011, 10'd3});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) clr_req = 1'b0;
      #1;
      check("clr_sweep", {busy, mem_wen, mem_ren, bus.r0_ack, mem_wad, mem_wda},
            {4'b1100, 10'(i), 18'h0});
      if (i == 1)
        check("clr_inflight", {bus.rd_vld, bus.rd_id, bus.rd_da}, {2'b10, 18'h155});
    end
    @(negedge clk); #1;
    check("post_clr_gnt", {busy, bus.r0_ack, mem_ren, mem_rad}, {3'b011, 10'd3});
    @(negedge clk); bus.r0_req = 1'b0; #1;
    @(negedge clk); #1;
    check("post_clr_ret", {bus.rd_vld, bus.rd_id, bus.rd_da}, {2'b10, 18'h0});

    // rst one cycle after a read ack
    @(negedge clk); bus.r0_req = 1'b1; bus.r0_ad = 10'd5; #1;
    check("pre_rst_gnt", {bus.r0_ack, mem_rad}, {1'b1, 10'd5});
    @(negedge clk); bus.r0_req = 1'b0; rst = 1'b1; #1;
    check("rst_mid", {busy, mem_wen, bus.rd_vld}, 3'b100);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_flush", {bus.rd_vld, busy, mem_wen, mem_wad}, {3'b011, 10'd0});
    @(negedge clk); #1;
    check("rst_sweep1", {bus.rd_vld, mem_wen, mem_wad}, {2'b01, 10'd1});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
